// File: rtl/mem_access_unit_if.sv
// Handshake and bus bundle around mem_access_unit: execute-stage offer,
// data-memory req/ack port and write-back record.
// master: the memory-access stage itself; slave: the surrounding pipeline,
// i.e. the execute stage, the data memory and the write-back stage.
interface mem_access_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_AW = 5
);
   localparam int LANES = DATA_W / 8;

   logic              in_valid;
   logic              in_ready;
   logic              in_load;
   logic              in_store;
   logic [1:0]        in_size;
   logic              in_signed;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_wdata;
   logic [DATA_W-1:0] in_result;
   logic [REG_AW-1:0] in_rd;
   logic              in_rwr;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [LANES-1:0]  mem_wmask;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   logic              wb_valid;
   logic [DATA_W-1:0] wb_data;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_rwr;
   logic              wb_exc;

   modport master (
      input  in_valid, in_load, in_store, in_size, in_signed, in_addr,
             in_wdata, in_result, in_rd, in_rwr, mem_rdata, mem_ack,
      output in_ready, mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
             wb_valid, wb_data, wb_rd, wb_rwr, wb_exc
   );

   modport slave (
      output in_valid, in_load, in_store, in_size, in_signed, in_addr,
             in_wdata, in_result, in_rd, in_rwr, mem_rdata, mem_ack,
      input  in_ready, mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
             wb_valid, wb_data, wb_rd, wb_rwr, wb_exc
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage between execute and write-back.
// Accepts one operation per handshake in IDLE. Non-memory operations and
// misaligned accesses produce a write-back record one cycle later; aligned
// loads/stores hold a req/ack bus transaction in BUSY, then write back the
// lane-extracted, extended load data (or the forwarded result for stores).
module mem_access_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_AW = 5
) (
   input logic               clk,
   input logic               rst,
   mem_access_unit_if.master bus
);
   localparam int LANES = DATA_W / 8;
   localparam int OFF_W = $clog2(LANES);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   // Byte-lane enables for a 2^size byte access starting at lane off.
   function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size,
                                                  input logic [OFF_W-1:0] off);
      logic [LANES-1:0] base;
      for (int i = 0; i < LANES; i++) base[i] = (i < (32'sd1 <<< size));
      return base << off;
   endfunction

   // Address error when the low address bits are not a multiple of 2^size.
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] low);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return low[0];
         2'd2:    return |low[1:0];
         default: return |low;
      endcase
   endfunction

   // Move the addressed lanes down to bit 0 and sign/zero-extend them.
   function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                     input logic [OFF_W-1:0]  off,
                                                     input logic [1:0]        size,
                                                     input logic              sgn);
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] res;
      logic              fill;
      sh = raw >> {off, 3'b000};
      case (size)
         2'd0:    fill = sgn & sh[7];
         2'd1:    fill = sgn & sh[15];
         2'd2:    fill = sgn & sh[31];
         default: fill = sgn & sh[DATA_W-1];
      endcase
      for (int i = 0; i < DATA_W; i++) res[i] = (i < (32'sd8 <<< size)) ? sh[i] : fill;
      return res;
   endfunction

   state_t            state_r, state_next_s;
   logic              accept_s;
   logic [1:0]        size_eff_s;
   logic [OFF_W-1:0]  off_s;
   logic              is_mem_s;
   logic              is_load_s;
   logic              misaligned_s;
   logic [LANES-1:0]  mask_s;

   logic              mem_req_r, mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [LANES-1:0]  mem_wmask_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              wb_valid_r, wb_rwr_r, wb_exc_r;
   logic [DATA_W-1:0] wb_data_r;
   logic [REG_AW-1:0] wb_rd_r;

   logic              cap_load_r, cap_signed_r, cap_rwr_r;
   logic [1:0]        cap_size_r;
   logic [OFF_W-1:0]  cap_off_r;
   logic [REG_AW-1:0] cap_rd_r;
   logic [DATA_W-1:0] cap_result_r;

   // Decode the offered operation; doubleword on a 32-bit bus is a word.
   always_comb begin
      if ((LANES == 32'sd4) && (bus.in_size == 2'd3)) size_eff_s = 2'd2;
      else size_eff_s = bus.in_size;
      off_s        = bus.in_addr[OFF_W-1:0];
      is_load_s    = bus.in_load;
      is_mem_s     = bus.in_load | bus.in_store;
      misaligned_s = is_mem_s & misaligned(size_eff_s, bus.in_addr[2:0]);
      mask_s       = lane_mask(size_eff_s, off_s);
   end

   // State register; reset abandons any outstanding transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= ST_IDLE;
      else      state_r <= state_next_s;
   end

   // Next state: only aligned memory operations enter BUSY; ack returns to IDLE.
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               accept_s = 1'b1;
               if (is_mem_s && !misaligned_s) state_next_s = ST_BUSY;
               else state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (bus.mem_ack) state_next_s = ST_IDLE;
            else state_next_s = ST_BUSY;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Bus outputs, captured operation fields and the write-back record.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req_r    <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= '0;
         mem_wmask_r  <= '0;
         mem_wdata_r  <= '0;
         wb_valid_r   <= 1'b0;
         wb_data_r    <= '0;
         wb_rd_r      <= '0;
         wb_rwr_r     <= 1'b0;
         wb_exc_r     <= 1'b0;
         cap_load_r   <= 1'b0;
         cap_signed_r <= 1'b0;
         cap_rwr_r    <= 1'b0;
         cap_size_r   <= 2'd0;
         cap_off_r    <= '0;
         cap_rd_r     <= '0;
         cap_result_r <= '0;
      end else begin
         wb_valid_r <= 1'b0;
         if (accept_s && !is_mem_s) begin
            wb_valid_r <= 1'b1;
            wb_data_r  <= bus.in_result;
            wb_rd_r    <= bus.in_rd;
            wb_rwr_r   <= bus.in_rwr;
            wb_exc_r   <= 1'b0;
         end else if (accept_s && misaligned_s) begin
            wb_valid_r <= 1'b1;
            wb_data_r  <= bus.in_result;
            wb_rd_r    <= bus.in_rd;
            wb_rwr_r   <= 1'b0;
            wb_exc_r   <= 1'b1;
         end else if (accept_s) begin
            mem_req_r    <= 1'b1;
            mem_we_r     <= ~is_load_s;
            mem_addr_r   <= {bus.in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wmask_r  <= mask_s;
            mem_wdata_r  <= bus.in_wdata << {off_s, 3'b000};
            cap_load_r   <= is_load_s;
            cap_signed_r <= bus.in_signed;
            cap_rwr_r    <= bus.in_rwr;
            cap_size_r   <= size_eff_s;
            cap_off_r    <= off_s;
            cap_rd_r     <= bus.in_rd;
            cap_result_r <= bus.in_result;
         end else if ((state_r == ST_BUSY) && bus.mem_ack) begin
            mem_req_r  <= 1'b0;
            wb_valid_r <= 1'b1;
            wb_data_r  <= cap_load_r ? load_extend(bus.mem_rdata, cap_off_r, cap_size_r, cap_signed_r)
                                     : cap_result_r;
            wb_rd_r    <= cap_rd_r;
            wb_rwr_r   <= cap_load_r & cap_rwr_r;
            wb_exc_r   <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = (state_r == ST_IDLE);
   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wmask = mem_wmask_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.wb_valid  = wb_valid_r;
   assign bus.wb_data   = wb_data_r;
   assign bus.wb_rd     = wb_rd_r;
   assign bus.wb_rwr    = wb_rwr_r;
   assign bus.wb_exc    = wb_exc_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a 32-bit and a 64-bit instance,
// directed scenarios plus randomized operations against a byte-level model.
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mem_access_unit_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) bus32 ();
   mem_access_unit_if #(.DATA_W(64), .ADDR_W(32), .REG_AW(5)) bus64 ();

   mem_access_unit #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) dut32 (.clk(clk), .rst(rst), .bus(bus32.master));
   mem_access_unit #(.DATA_W(64), .ADDR_W(32), .REG_AW(5)) dut64 (.clk(clk), .rst(rst), .bus(bus64.master));

   typedef struct packed {
      logic        load;
      logic        store;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] result;
      logic [4:0]  rd;
      logic        rwr;
      logic [63:0] rdata;
      logic [3:0]  waitn;
   } op_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [7:0]  mask;
      logic [63:0] wdata;
      logic        wb_valid;
      logic [63:0] wb_data;
      logic [4:0]  wb_rd;
      logic        wb_rwr;
      logic        wb_exc;
      logic        ready;
   } obs_t;

   // Reference: what one operation must produce, from byte arithmetic.
   function automatic obs_t model(input op_t op, input int lanes);
      obs_t        e;
      int          nb, off;
      logic [63:0] full, keep, v;
      e = '0;
      full = (lanes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      nb = 1 << op.size;
      if (nb > lanes) nb = lanes;
      off = int'(op.addr & 32'(lanes - 1));
      e.wb_valid = 1'b1;
      e.ready = 1'b1;
      e.wb_rd = op.rd;
      e.wb_data = op.result & full;
      if (!(op.load || op.store)) begin
         e.wb_rwr = op.rwr;
      end else if ((op.addr & 32'(nb - 1)) != 32'd0) begin
         e.wb_exc = 1'b1;
      end else begin
         e.req = 1'b1;
         e.we = !op.load;
         e.addr = op.addr - 32'(off);
         e.mask = 8'(((1 << nb) - 1) << off);
         e.wdata = (op.wdata << (8 * off)) & full;
         if (op.load) begin
            keep = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
            v = ((op.rdata & full) >> (8 * off)) & keep;
            if (op.sgn && (((v >> (8 * nb - 1)) & 64'd1) != 64'd0)) v = v | ~keep;
            e.wb_data = v & full;
            e.wb_rwr = op.rwr;
         end
      end
      return e;
   endfunction

   task automatic set_inputs(input bit wide, input op_t op, input logic v);
      if (wide) begin
         bus64.in_valid = v; bus64.in_load = op.load; bus64.in_store = op.store;
         bus64.in_size = op.size; bus64.in_signed = op.sgn; bus64.in_addr = op.addr;
         bus64.in_wdata = op.wdata; bus64.in_result = op.result;
         bus64.in_rd = op.rd; bus64.in_rwr = op.rwr;
      end else begin
         bus32.in_valid = v; bus32.in_load = op.load; bus32.in_store = op.store;
         bus32.in_size = op.size; bus32.in_signed = op.sgn; bus32.in_addr = op.addr;
         bus32.in_wdata = op.wdata[31:0]; bus32.in_result = op.result[31:0];
         bus32.in_rd = op.rd; bus32.in_rwr = op.rwr;
      end
   endtask

   task automatic set_ack(input bit wide, input logic a, input logic [63:0] rdata);
      if (wide) begin
         bus64.mem_ack = a; bus64.mem_rdata = rdata;
      end else begin
         bus32.mem_ack = a; bus32.mem_rdata = rdata[31:0];
      end
   endtask

   task automatic sample(input bit wide, output obs_t o);
      o = '0;
      if (wide) begin
         o.req = bus64.mem_req; o.we = bus64.mem_we; o.addr = bus64.mem_addr;
         o.mask = bus64.mem_wmask; o.wdata = bus64.mem_wdata;
         o.wb_valid = bus64.wb_valid; o.wb_data = bus64.wb_data; o.wb_rd = bus64.wb_rd;
         o.wb_rwr = bus64.wb_rwr; o.wb_exc = bus64.wb_exc; o.ready = bus64.in_ready;
      end else begin
         o.req = bus32.mem_req; o.we = bus32.mem_we; o.addr = bus32.mem_addr;
         o.mask = {4'h0, bus32.mem_wmask}; o.wdata = {32'h0, bus32.mem_wdata};
         o.wb_valid = bus32.wb_valid; o.wb_data = {32'h0, bus32.wb_data}; o.wb_rd = bus32.wb_rd;
         o.wb_rwr = bus32.wb_rwr; o.wb_exc = bus32.wb_exc; o.ready = bus32.in_ready;
      end
   endtask

   // Offer one operation, answer the bus after op.waitn wait cycles; returns
   // the cycle after acceptance, the write-back cycle and whether the bus
   // outputs stayed stable (with in_ready low) through the wait cycles.
   task automatic run_op(input bit wide, input op_t op, output obs_t bus_s,
                         output obs_t wb_s, output bit held);
      obs_t t;
      @(negedge clk);
      set_inputs(wide, op, 1'b1);
      @(negedge clk);
      set_inputs(wide, op, 1'b0);
      sample(wide, bus_s);
      held = 1'b1;
      if (bus_s.req === 1'b1) begin
         for (int i = 0; i < int'(op.waitn); i++) begin
            @(negedge clk);
            sample(wide, t);
            if (t.req !== 1'b1 || t.we !== bus_s.we || t.addr !== bus_s.addr ||
                t.mask !== bus_s.mask || t.wdata !== bus_s.wdata ||
                t.ready !== 1'b0 || t.wb_valid !== 1'b0) held = 1'b0;
         end
         set_ack(wide, 1'b1, op.rdata);
         @(negedge clk);
         set_ack(wide, 1'b0, 64'h0);
         sample(wide, wb_s);
      end else begin
         wb_s = bus_s;
      end
   endtask

   task automatic test_reset;
      obs_t o, e;
      e = '0;
      e.ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         sample(w[0], o);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_state w%0d got %h expected %h", w, o, e);
         end
      end
   endtask

   task automatic test_pass_through;
      op_t  op;
      obs_t b, w, o;
      bit   h;
      op = '0;
      op.result = 64'h1234_5678; op.rd = 5'd3; op.rwr = 1'b1;
      run_op(1'b0, op, b, w, h);
      n_checks++;
      if ({b.wb_valid, b.wb_data, b.wb_rd, b.wb_rwr, b.wb_exc, b.req} !==
          {1'b1, 64'h1234_5678, 5'd3, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL pass_wb got v%b d%h rd%0d rwr%b exc%b req%b expected v1 d12345678 rd3 rwr1 exc0 req0",
                  b.wb_valid, b.wb_data, b.wb_rd, b.wb_rwr, b.wb_exc, b.req);
      end
      @(negedge clk);
      sample(1'b0, o);
      n_checks++;
      if (o.wb_valid !== 1'b0 || o.ready !== 1'b1) begin
         n_fail++;
         $display("FAIL pass_pulse got wb_valid %b ready %b expected 0 1", o.wb_valid, o.ready);
      end
   endtask

   task automatic test_signed_byte_load;
      op_t  op;
      obs_t b, w;
      bit   h;
      op = '0;
      op.load = 1'b1; op.size = 2'd0; op.sgn = 1'b1; op.addr = 32'h1003;
      op.rdata = 64'h80AA_BBCC; op.rd = 5'd7; op.rwr = 1'b1; op.waitn = 4'd3;
      run_op(1'b0, op, b, w, h);
      n_checks++;
      if ({b.req, b.we, b.addr, b.mask, b.ready} !== {1'b1, 1'b0, 32'h1000, 8'h08, 1'b0}) begin
         n_fail++;
         $display("FAIL lb_bus got req%b we%b addr%h mask%h ready%b expected req1 we0 addr00001000 mask08 ready0",
                  b.req, b.we, b.addr, b.mask, b.ready);
      end
      n_checks++;
      if (h !== 1'b1) begin
         n_fail++;
         $display("FAIL lb_hold got stable %b expected 1", h);
      end
      n_checks++;
      if ({w.wb_valid, w.wb_data, w.wb_rd, w.wb_rwr, w.ready, w.req} !==
          {1'b1, 64'hFFFF_FF80, 5'd7, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL lb_wb got v%b d%h rd%0d rwr%b ready%b req%b expected v1 dffffff80 rd7 rwr1 ready1 req0",
                  w.wb_valid, w.wb_data, w.wb_rd, w.wb_rwr, w.ready, w.req);
      end
   endtask

   task automatic test_half_store;
      op_t  op;
      obs_t b, w;
      bit   h;
      op = '0;
      op.store = 1'b1; op.size = 2'd1; op.addr = 32'h2002; op.wdata = 64'h0000_BEEF;
      op.rd = 5'd9; op.rwr = 1'b1; op.waitn = 4'd1;
      run_op(1'b0, op, b, w, h);
      n_checks++;
      if ({b.req, b.we, b.addr, b.mask, b.wdata} !== {1'b1, 1'b1, 32'h2000, 8'h0C, 64'hBEEF_0000}) begin
         n_fail++;
         $display("FAIL sh_bus got req%b we%b addr%h mask%h wdata%h expected req1 we1 addr00002000 mask0c wdata beef0000",
                  b.req, b.we, b.addr, b.mask, b.wdata);
      end
      n_checks++;
      if ({w.wb_valid, w.wb_rwr, w.wb_exc} !== {1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL sh_wb got v%b rwr%b exc%b expected v1 rwr0 exc0", w.wb_valid, w.wb_rwr, w.wb_exc);
      end
   endtask

   task automatic test_misaligned;
      op_t  op;
      obs_t b, w, o;
      bit   h;
      op = '0;
      op.load = 1'b1; op.size = 2'd2; op.addr = 32'h3001; op.rd = 5'd4; op.rwr = 1'b1;
      run_op(1'b0, op, b, w, h);
      n_checks++;
      if ({b.wb_valid, b.wb_exc, b.wb_rwr, b.req, b.ready} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL misalign got v%b exc%b rwr%b req%b ready%b expected v1 exc1 rwr0 req0 ready1",
                  b.wb_valid, b.wb_exc, b.wb_rwr, b.req, b.ready);
      end
      @(negedge clk);
      sample(1'b0, o);
      n_checks++;
      if ({o.req, o.wb_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL misalign_after got req%b wb_valid%b expected 0 0", o.req, o.wb_valid);
      end
   endtask

   task automatic test_wide;
      op_t  op;
      obs_t b, w, e;
      bit   h;
      op = '0;
      op.load = 1'b1; op.size = 2'd2; op.addr = 32'h4004; op.rdata = 64'h8765_4321_0000_0000;
      op.rd = 5'd2; op.rwr = 1'b1;
      run_op(1'b1, op, b, w, h);
      n_checks++;
      if ({b.addr, b.mask, w.wb_data, w.wb_valid} !== {32'h4000, 8'hF0, 64'h0000_0000_8765_4321, 1'b1}) begin
         n_fail++;
         $display("FAIL lw64 got addr%h mask%h data%h v%b expected addr00004000 maskf0 data0000000087654321 v1",
                  b.addr, b.mask, w.wb_data, w.wb_valid);
      end
      for (int k = 0; k < 16; k++) begin
         rand_op(op);
         e = model(op, 8);
         run_op(1'b1, op, b, w, h);
         n_checks++;
         if (b.req !== e.req || (e.req && {b.we, b.addr, b.mask, h} !== {e.we, e.addr, e.mask, 1'b1})) begin
            n_fail++;
            $display("FAIL rand64[%0d] bus got req%b we%b addr%h mask%h stable%b expected req%b we%b addr%h mask%h stable1",
                     k, b.req, b.we, b.addr, b.mask, h, e.req, e.we, e.addr, e.mask);
         end
         n_checks++;
         if ({w.wb_valid, w.wb_data, w.wb_rd, w.wb_rwr, w.wb_exc} !==
             {e.wb_valid, e.wb_data, e.wb_rd, e.wb_rwr, e.wb_exc}) begin
            n_fail++;
            $display("FAIL rand64[%0d] wb got v%b d%h rd%0d rwr%b exc%b expected v%b d%h rd%0d rwr%b exc%b", k,
                     w.wb_valid, w.wb_data, w.wb_rd, w.wb_rwr, w.wb_exc,
                     e.wb_valid, e.wb_data, e.wb_rd, e.wb_rwr, e.wb_exc);
         end
      end
   endtask

   task automatic rand_op(output op_t op);
      op = '0;
      case ($urandom_range(0, 3))
         0: begin op.load = 1'b0; op.store = 1'b0; end
         1: op.load = 1'b1;
         2: op.store = 1'b1;
         default: begin op.load = 1'b1; op.store = 1'b1; end
      endcase
      op.size = 2'($urandom_range(0, 3));
      op.sgn = 1'($urandom_range(0, 1));
      op.addr = $urandom;
      if ($urandom_range(0, 2) != 0) op.addr = op.addr & ~32'((1 << op.size) - 1);
      op.wdata = {$urandom, $urandom};
      op.result = {$urandom, $urandom};
      op.rdata = {$urandom, $urandom};
      op.rd = 5'($urandom);
      op.rwr = 1'($urandom_range(0, 1));
      op.waitn = 4'($urandom_range(0, 3));
   endtask

   task automatic test_random;
      op_t  op;
      obs_t b, w, e;
      bit   h;
      for (int k = 0; k < 40; k++) begin
         rand_op(op);
         e = model(op, 4);
         run_op(1'b0, op, b, w, h);
         n_checks++;
         if (b.req !== e.req) begin
            n_fail++;
            $display("FAIL rand[%0d] req got %b expected %b", k, b.req, e.req);
         end
         if (e.req) begin
            n_checks++;
            if ({b.we, b.addr, b.mask, b.ready, b.wb_valid, h} !== {e.we, e.addr, e.mask, 1'b0, 1'b0, 1'b1}) begin
               n_fail++;
               $display("FAIL rand[%0d] bus got we%b addr%h mask%h ready%b v%b stable%b expected we%b addr%h mask%h ready0 v0 stable1",
                        k, b.we, b.addr, b.mask, b.ready, b.wb_valid, h, e.we, e.addr, e.mask);
            end
            if (e.we) begin
               n_checks++;
               if (b.wdata !== e.wdata) begin
                  n_fail++;
                  $display("FAIL rand[%0d] wdata got %h expected %h", k, b.wdata, e.wdata);
               end
            end
         end
         n_checks++;
         if ({w.wb_valid, w.wb_data, w.wb_rd, w.wb_rwr, w.wb_exc, w.ready, w.req} !==
             {e.wb_valid, e.wb_data, e.wb_rd, e.wb_rwr, e.wb_exc, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rand[%0d] wb got v%b d%h rd%0d rwr%b exc%b ready%b req%b expected v%b d%h rd%0d rwr%b exc%b ready1 req0",
                     k, w.wb_valid, w.wb_data, w.wb_rd, w.wb_rwr, w.wb_exc, w.ready, w.req,
                     e.wb_valid, e.wb_data, e.wb_rd, e.wb_rwr, e.wb_exc);
         end
      end
   endtask

   task automatic test_back_to_back;
      op_t         op;
      obs_t        o;
      logic [63:0] res [6];
      op = '0;
      op.rwr = 1'b1;
      for (int i = 0; i < 6; i++) res[i] = {32'h0, $urandom};
      @(negedge clk);
      op.result = res[0]; op.rd = 5'd0;
      set_inputs(1'b0, op, 1'b1);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         sample(1'b0, o);
         n_checks++;
         if ({o.wb_valid, o.wb_data, o.wb_rd, o.ready} !== {1'b1, res[i-1], 5'(i - 1), 1'b1}) begin
            n_fail++;
            $display("FAIL b2b[%0d] got v%b d%h rd%0d ready%b expected v1 d%h rd%0d ready1",
                     i - 1, o.wb_valid, o.wb_data, o.wb_rd, o.ready, res[i-1], i - 1);
         end
         if (i < 6) begin
            op.result = res[i]; op.rd = 5'(i);
            set_inputs(1'b0, op, 1'b1);
         end else begin
            set_inputs(1'b0, op, 1'b0);
         end
      end
   endtask

   task automatic test_reset_busy;
      op_t  op;
      obs_t o;
      op = '0;
      op.load = 1'b1; op.size = 2'd2; op.addr = 32'h5000; op.rd = 5'd6; op.rwr = 1'b1;
      @(negedge clk);
      set_inputs(1'b0, op, 1'b1);
      @(negedge clk);
      set_inputs(1'b0, op, 1'b0);
      sample(1'b0, o);
      n_checks++;
      if (o.req !== 1'b1) begin
         n_fail++;
         $display("FAIL rstbusy_req got %b expected 1", o.req);
      end
      #2 rst = 1'b0;
      #1 sample(1'b0, o);
      n_checks++;
      if (o.req !== 1'b0) begin
         n_fail++;
         $display("FAIL rstbusy_async got mem_req %b expected 0", o.req);
      end
      @(negedge clk);
      rst = 1'b1;
      set_ack(1'b0, 1'b1, 64'h1111_2222);
      @(negedge clk);
      set_ack(1'b0, 1'b0, 64'h0);
      for (int i = 0; i < 2; i++) begin
         sample(1'b0, o);
         n_checks++;
         if ({o.wb_valid, o.ready, o.req} !== 3'b010) begin
            n_fail++;
            $display("FAIL rstbusy_late_ack[%0d] got v%b ready%b req%b expected v0 ready1 req0",
                     i, o.wb_valid, o.ready, o.req);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      set_inputs(1'b0, '0, 1'b0);
      set_inputs(1'b1, '0, 1'b0);
      set_ack(1'b0, 1'b0, 64'h0);
      set_ack(1'b1, 1'b0, 64'h0);
      test_reset();
      test_pass_through();
      test_signed_byte_load();
      test_half_store();
      test_misaligned();
      test_wide();
      test_random();
      test_back_to_back();
      test_reset_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised, multi-cycle memory-access pipeline stage between the execute stage and the write-back stage of the MIPS core. It accepts one operation per handshake, drives a req/ack data-memory port with byte-lane masks, and aligns and sign/zero-extends sub-word loads. It flags misaligned accesses without touching the bus and stalls upstream while a bus transaction is outstanding. Non-memory operations pass through with one cycle of latency.

## Interface
- DATA_W, 32, data-bus width; legal values are 32 or 64. LANES = DATA_W/8; OFF_W = log2(LANES).
- ADDR_W, 32, byte-address width.
- REG_AW, 5, register-file address width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  an execute-stage operation is present.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- in_load, in_store  in  1 each  operation type; both 0 means pass-through; both 1 is illegal and is treated as load.
- in_size  in  2  access size: 0 byte, 1 half, 2 word, 3 doubleword (DATA_W=64 only; with DATA_W=32 it is treated as word).
- in_signed  in  1  sign-extend loads.
- in_addr  in  ADDR_W  byte address.
- in_wdata  in  DATA_W  store data, right-justified.
- in_result  in  DATA_W  ALU result forwarded for non-loads.
- in_rd, in_rwr  in  REG_AW, 1  destination register and its write enable.
- mem_req  out  1  bus request, held until mem_ack.
- mem_we  out  1  write.
- mem_addr  out  ADDR_W  address aligned to LANES (low OFF_W bits forced to 0).
- mem_wmask  out  LANES  byte-lane enables (used for reads and writes).
- mem_wdata  out  DATA_W  store data shifted to its lanes.
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle.
- mem_ack  in  1  transaction complete.
- wb_valid  out  1  write-back record valid (one-cycle pulse per operation).
- wb_data  out  DATA_W  load result or in_result.
- wb_rd, wb_rwr  out  REG_AW, 1  destination; wb_rwr is forced to 0 on exception.
- wb_exc  out  1  misaligned access (address error).

## Operation
- FSM states: IDLE and BUSY.
- IDLE, in_valid=1:
  - Non-memory operation: the wb record is registered next cycle (wb_data=in_result). State stays IDLE.
  - Memory operation with a misaligned address (address mod 2^size != 0): next cycle wb_valid=1, wb_exc=1, wb_rwr=0. No mem_req is issued.
  - Aligned memory operation: fields are captured, mem_req=1 from the next cycle, state goes to BUSY.
- BUSY: mem_req and all mem_* outputs are held stable until mem_ack=1.
  - On ack, wb_valid=1 next cycle. For loads, wb_data = the extracted lanes, extended; stores give wb_rwr=0.
  - State returns to IDLE, and in_ready rises in the same cycle that wb_valid is asserted.
- mem_ack outside BUSY is ignored.
- Lane offset is off = addr[OFF_W-1:0].
  - Mask is ((1<<(1<<size))-1) << off.
  - mem_wdata is in_wdata << (8*off).
  - Load data is (mem_rdata >> 8*off), truncated to 8<<size bits and extended to DATA_W: sign-extended if in_signed, else zero-extended.
- Reset values: state=IDLE; every output register is 0, including mem_req, mem_we, mem_addr, mem_wmask, mem_wdata, wb_* and wb_exc. in_ready=1 once reset is released.
- Asserting reset in BUSY abandons the transaction immediately. mem_req drops asynchronously and no wb record is produced.

## Timing
- Pass-through and exception latency: 1 cycle from acceptance to wb_valid.
- Memory latency: 1 cycle to mem_req, plus N bus-wait cycles, plus 1 cycle to wb_valid. Minimum is 2 cycles with same-cycle ack (ack in the first mem_req cycle).
- Throughput: one operation per cycle for non-memory traffic. Memory operations block further acceptance while BUSY.
- If in_valid is high while in_ready is low, the input is not consumed. Upstream must hold the operation.

## Test plan
- Pass-through: in_result=0x1234_5678, rd=3, rwr=1 → next cycle wb_valid=1, wb_data=0x1234_5678, wb_rd=3, no mem_req.
- Signed byte load at addr 0x1003, mem_rdata=0x80AA_BBCC, ack 3 cycles after req → mem_addr=0x1000, mask=4'b1000, wb_data=0xFFFF_FF80; in_ready is 0 during the wait.
- Half store: 0x0000_BEEF at addr 0x2002 → mem_we=1, mask=4'b1100, mem_wdata=0xBEEF_0000, wb_rwr=0.
- Misaligned word load at 0x3001 → wb_exc=1, wb_rwr=0 after 1 cycle; mem_req stays 0.
- DATA_W=64, unsigned word load at 0x4004, rdata=0x8765_4321_0000_0000 → mask=8'hF0, wb_data=0x0000_0000_8765_4321.
- Reset asserted in BUSY before ack → mem_req=0 asynchronously, in_ready=1 after release, and a later ack produces no wb_valid.
